// File: rtl/aes_diff_pkg.sv
// Shared types, GF(2^8) helpers and row-shift functions for the AES diffusion engine.
// State layout is column-major: byte 4c+r lives at bits [127-8*(4c+r) -: 8].
package aes_diff_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    typedef enum logic [1:0] {IDLE, MIX, DONE} fsm_t;

    localparam col_t MIX_FWD = 32'h0203_0101;
    localparam col_t MIX_INV = 32'h0e0b_0d09;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    // Row r rotates left by r byte positions.
    function automatic state_t shift_rows(input state_t s);
        state_t t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return t;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/mix_col_unit.sv
// Combinational single-column (Inv)MixColumns: each output row is the dot product of the
// column with the coefficient row rotated right by the row index.
module mix_col_unit
    import aes_diff_pkg::*;
(
    input  col_t col_i,
    input  logic inv_i,
    output col_t col_o
);

    col_t       coef;
    logic [7:0] acc;

    always_comb begin
        coef  = inv_i ? MIX_INV : MIX_FWD;
        col_o = '0;
        acc   = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) begin
                acc = acc ^ gf_mul(coef[31 - 8*((k - r + 4) % 4) -: 8], col_i[31 - 8*k -: 8]);
            end
            col_o[31 - 8*r -: 8] = acc;
        end
    end

endmodule

// File: rtl/diffusion_iter.sv
// Iterative AES ShiftRows+MixColumns / InvMixColumns+InvShiftRows engine with
// valid/ready on both sides, mixing COLS_PER_CYCLE columns per clock.
module diffusion_iter
    import aes_diff_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    input  logic         in_skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $fatal(1, "diffusion_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // With four units the column pointer wraps to itself and stays at 0.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    fsm_t       fsm_q, fsm_d;
    logic [1:0] col_q, col_d;
    state_t     state_q, state_d;
    logic       inv_q, inv_d;
    logic       skip_q, skip_d;
    logic       out_valid_q, out_valid_d;
    logic       accept;

    col_t       cols    [4];
    col_t       cols_d  [4];
    col_t       mix_in  [COLS_PER_CYCLE];
    col_t       mix_out [COLS_PER_CYCLE];
    logic [1:0] mix_idx [COLS_PER_CYCLE];

    always_comb begin
        for (int c = 0; c < 4; c++) cols[c] = state_q[127 - 32*c -: 32];
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
        assign mix_idx[g] = col_q + 2'(g);
        assign mix_in[g]  = cols[mix_idx[g]];

        mix_col_unit u_mix (
            .col_i (mix_in[g]),
            .inv_i (inv_q),
            .col_o (mix_out[g])
        );
    end

    always_comb begin
        fsm_d   = fsm_q;
        col_d   = col_q;
        state_d = state_q;
        inv_d   = inv_q;
        skip_d  = skip_q;
        cols_d  = cols;

        in_ready = (fsm_q == IDLE) || (fsm_q == DONE && out_ready);
        accept   = in_valid && in_ready;

        case (fsm_q)
            MIX: begin
                for (int g = 0; g < int'(COLS_PER_CYCLE); g++) cols_d[mix_idx[g]] = mix_out[g];
                for (int c = 0; c < 4; c++) state_d[127 - 32*c -: 32] = cols_d[c];
                col_d = col_q + COL_STEP;
                // A skip block never enters MIX; the term only guards against it.
                if (col_q == LAST_COL || skip_q) fsm_d = DONE;
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: ;
        endcase

        // Accepting from DONE overrides the return to IDLE for back-to-back blocks.
        if (accept) begin
            state_d = in_inv ? in_state : shift_rows(in_state);
            inv_d   = in_inv;
            skip_d  = in_skip_mix;
            col_d   = '0;
            fsm_d   = in_skip_mix ? DONE : MIX;
        end

        out_valid_d = (fsm_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            col_q       <= '0;
            state_q     <= '0;
            inv_q       <= 1'b0;
            skip_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            col_q       <= col_d;
            state_q     <= state_d;
            inv_q       <= inv_d;
            skip_q      <= skip_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = inv_q ? inv_shift_rows(state_q) : state_q;

endmodule

// File: tb/tb_diffusion_iter.sv
// Scoreboard bench for diffusion_iter: three instances (1, 2 and 4 columns per cycle)
// checked against a byte-matrix AES reference model, with latency and stall checks.
module tb_diffusion_iter;

    localparam int NDUT = 3;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    localparam logic [127:0] FWD_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FWD_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] SEQ     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_SR  = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] COL_IN  = 128'hdb135345db135345db135345db135345;
    localparam logic [127:0] COL_OUT = 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [127:0] in_state  [NDUT];
    logic         in_inv    [NDUT];
    logic         in_skip   [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] out_state [NDUT];
    logic         rnd_rdy   [NDUT];
    logic         man_rdy   [NDUT];
    int           rdy_mode = 0;

    int           cyc   = 0;
    int           total = 0;
    int           bad   = 0;
    bit           mon_en = 1'b0;
    exp_t         sb [NDUT][$];
    bit           fresh   [NDUT];
    bit           stalled [NDUT];
    logic [127:0] held    [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        assign out_ready[gi] = (rdy_mode == 2) ? man_rdy[gi] :
                               (rdy_mode == 1) ? rnd_rdy[gi] : 1'b1;

        initial begin
            rnd_rdy[gi] = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                rnd_rdy[gi] = ($urandom_range(0, 3) != 0);
            end
        end

        diffusion_iter #(
            .COLS_PER_CYCLE (1 << gi)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid[gi]),
            .in_ready    (in_ready[gi]),
            .in_state    (in_state[gi]),
            .in_inv      (in_inv[gi]),
            .in_skip_mix (in_skip[gi]),
            .out_valid   (out_valid[gi]),
            .out_ready   (out_ready[gi]),
            .out_state   (out_state[gi])
        );
    end

    task automatic chk(input int d, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL dut%0d %s: got %h wanted %h", d, name, act, exp);
        end
    endtask

    // Reference model on a 4x4 byte matrix, row r / column c.
    function automatic logic [7:0] bget(input logic [127:0] s, input int r, input int c);
        return s[127 - 8*(4*c + r) -: 8];
    endfunction

    function automatic logic [127:0] bput(input logic [127:0] s, input int r, input int c,
                                          input logic [7:0] v);
        logic [127:0] t;
        t = s;
        t[127 - 8*(4*c + r) -: 8] = v;
        return t;
    endfunction

    function automatic logic [127:0] rotate_rows(input logic [127:0] s, input int dir);
        logic [127:0] t;
        t = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t = bput(t, r, c, bget(s, r, (c + dir*r + 8) % 4));
        return t;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input bit inv, input bit skip);
        int           fwd_row [4];
        int           inv_row [4];
        logic [127:0] t, m;
        logic [7:0]   acc;
        int           cf;
        fwd_row = '{2, 3, 1, 1};
        inv_row = '{14, 11, 13, 9};
        t = inv ? s : rotate_rows(s, 1);
        m = t;
        if (!skip) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++) begin
                        cf  = inv ? inv_row[(k - r + 4) % 4] : fwd_row[(k - r + 4) % 4];
                        acc = acc ^ gmul(8'(cf), bget(t, k, c));
                    end
                    m = bput(m, r, c, acc);
                end
            end
        end
        return inv ? rotate_rows(m, -1) : m;
    endfunction

    // Caller is just after a rising edge; returns just after the edge following acceptance.
    task automatic send(input int d, input logic [127:0] s, input bit inv, input bit skip,
                        input logic [127:0] exp, output int waits);
        exp_t e;
        in_valid[d] = 1'b1;
        in_state[d] = s;
        in_inv[d]   = inv;
        in_skip[d]  = skip;
        waits = 0;
        @(negedge clk);
        while (in_ready[d] !== 1'b1 && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (in_ready[d] !== 1'b1) begin
            chk(d, "accept_timeout", 128'(in_ready[d]), 128'd1);
        end else begin
            e.data = exp;
            e.due  = cyc + (skip ? 1 : (4 >> d) + 1);
            sb[d].push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_state[d] = {$urandom, $urandom, $urandom, $urandom};
        in_inv[d]   = 1'($urandom_range(0, 1));
        in_skip[d]  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(-1, "drain_pending", 128'(sb[0].size() + sb[1].size() + sb[2].size()), 128'd0);
    endtask

    task automatic rand_thread(input int d);
        int           w;
        logic [127:0] s;
        bit           inv, skip;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            s    = {$urandom, $urandom, $urandom, $urandom};
            inv  = 1'($urandom_range(0, 1));
            skip = ($urandom_range(0, 3) == 0);
            send(d, s, inv, skip, model(s, inv, skip), w);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst || !mon_en) begin
                fresh[d]   = 1'b1;
                stalled[d] = 1'b0;
            end else if (out_valid[d] === 1'b1) begin
                if (sb[d].size() == 0) begin
                    chk(d, "unexpected_output", 128'(out_valid[d]), 128'd0);
                end else begin
                    if (fresh[d]) chk(d, "latency", 128'(cyc), 128'(sb[d][0].due));
                    if (stalled[d]) chk(d, "stall_hold", out_state[d], held[d]);
                    if (out_ready[d]) begin
                        chk(d, "data", out_state[d], sb[d][0].data);
                        void'(sb[d].pop_front());
                    end
                end
                if (!out_ready[d]) chk(d, "stall_in_ready", 128'(in_ready[d]), 128'd0);
                fresh[d]   = out_ready[d];
                stalled[d] = !out_ready[d];
                held[d]    = out_state[d];
            end else begin
                fresh[d]   = 1'b1;
                stalled[d] = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d] = 1'b0;
            in_state[d] = '0;
            in_inv[d]   = 1'b0;
            in_skip[d]  = 1'b0;
            man_rdy[d]  = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk(d, "reset_in_ready", 128'(in_ready[d]), 128'd1);
            chk(d, "reset_out_valid", 128'(out_valid[d]), 128'd0);
            chk(d, "reset_out_state", out_state[d], 128'd0);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Known-answer vectors on every column width.
        for (int d = 0; d < NDUT; d++) begin
            send(d, FWD_IN, 1'b0, 1'b0, FWD_OUT, w);
            send(d, FWD_OUT, 1'b1, 1'b0, FWD_IN, w);
            send(d, SEQ, 1'b0, 1'b1, SEQ_SR, w);
            send(d, SEQ_SR, 1'b1, 1'b1, SEQ, w);
            send(d, COL_IN, 1'b0, 1'b0, COL_OUT, w);
        end
        drain();

        // Three-cycle stall in DONE, then release with a new block in the same cycle.
        rdy_mode   = 2;
        man_rdy[0] = 1'b0;
        send(0, FWD_IN, 1'b0, 1'b0, FWD_OUT, w);
        n = 0;
        @(negedge clk);
        while (out_valid[0] !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk(0, "stall_reach_done", 128'(out_valid[0]), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        man_rdy[0] = 1'b1;
        send(0, COL_IN, 1'b0, 1'b0, COL_OUT, w);
        chk(0, "b2b_accept_wait", 128'(w), 128'd0);
        drain();
        rdy_mode = 0;

        // Reset during the second MIX cycle of a one-column block.
        send(0, FWD_IN, 1'b0, 1'b0, FWD_OUT, w);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb[0].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(0, "rst_mid_out_valid", 128'(out_valid[0]), 128'd0);
        chk(0, "rst_mid_out_state", out_state[0], 128'd0);
        chk(0, "rst_mid_in_ready", 128'(in_ready[0]), 128'd1);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0) n++;
        end
        chk(0, "rst_no_stale", 128'(n), 128'd0);
        @(posedge clk);
        #1;

        // Random traffic with random backpressure on all three widths.
        rdy_mode = 1;
        fork
            rand_thread(0);
            rand_thread(1);
            rand_thread(2);
        join
        rdy_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/diffusion_iter.md
# diffusion_iter

Iterative, parametrised AES diffusion engine. It applies ShiftRows followed by MixColumns to a 128-bit state in forward mode, and the exact inverse, InvMixColumns followed by InvShiftRows, in inverse mode. A per-block bypass skips the column mix for the final round. The block sits between the substitution stage and the round-key add in the round datapath. It uses valid/ready handshakes on both sides and processes COLS_PER_CYCLE columns per clock, trading area for latency.

## Interface
- COLS_PER_CYCLE, default 1: number of mix-column units instantiated. Legal values are 1, 2 and 4; any other value is a fatal elaboration error.
- clk  in  1  single clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input block present.
- in_ready  out  1  engine can accept a block.
- in_state  in  128  state, column-major. Column c is at bits [127-32c -: 32]. Within a column the top row is the most significant byte, so byte 0 (FIPS s00) is bits [127:120].
- in_inv  in  1  0 = forward, 1 = inverse. Sampled at acceptance.
- in_skip_mix  in  1  1 = row shift only, no column mix. Sampled at acceptance.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_state  out  128  result, same byte order as in_state.

## Operation
- Acceptance occurs on a clock edge where in_valid and in_ready are both high. Ordering:
  - The input state is captured into state_q.
  - In forward mode, ShiftRows is applied on capture. Row r (0 = top) rotates left by r byte positions.
  - inv_q and skip_q are latched at the same edge.
- FSM states and transitions:
  - IDLE: on acceptance, go to DONE if in_skip_mix is 1, otherwise go to MIX.
  - MIX: each cycle, replace columns col_q .. col_q+COLS_PER_CYCLE-1 of state_q with their (Inv)MixColumns result. col_q then advances by COLS_PER_CYCLE. The FSM goes to DONE after the cycle that writes column 3.
  - DONE: out_valid=1. When out_ready=1, go to IDLE. If in_valid is also high in that cycle, accept the new block directly (go to MIX or DONE).
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back operation with no bubble.
- out_state = inv_q ? InvShiftRows(state_q) : state_q. Row r rotates right by r. This is a combinational output path from registers only.
- GF(2^8) arithmetic uses the polynomial 0x11b.
  - Forward matrix rows: {02 03 01 01} rotated.
  - Inverse matrix rows: {0e 0b 0d 09} rotated.
  - All products are reduced to 8 bits, and no carries are kept.
- in_inv, in_skip_mix and in_state are ignored whenever no acceptance occurs.
- While out_valid=1 and out_ready=0, out_state holds stable. in_ready stays 0 during this stall.

## Timing
- Reset values:
  - state=IDLE, col_q=0, state_q=0, inv_q=0, skip_q=0.
  - in_ready=1, out_valid=0, out_state=0.
  - The first in_ready=1 is in the cycle after rst falls.
- Latency, with acceptance in cycle E and N = 4/COLS_PER_CYCLE:
  - Mix blocks: out_valid first high in cycle E+N+1, giving E+5, E+3 and E+2 for COLS_PER_CYCLE = 1, 2 and 4.
  - Skip blocks: out_valid first high in cycle E+1.
- Sustained throughput: one block per N+1 cycles (mix) or one block per cycle (skip), provided out_ready is held at 1.
- Reset asserted in any state:
  - The in-flight block is discarded at that edge and all registers return to their reset values.
  - No out_valid pulse is produced for the discarded block.
- Simultaneous rst and in_valid: reset wins and the block is not accepted.

## Structure
- Package aes_diff_pkg contains:
  - the gf_xtime and gf_mul functions;
  - MIX_FWD and MIX_INV coefficient constants;
  - the state_t typedef (logic [127:0]) and the col_t typedef (logic [31:0]);
  - shift_rows and inv_shift_rows functions on state_t;
  - an fsm_t enum {IDLE, MIX, DONE}.
- Sub-module mix_col_unit: one combinational column mixer with an inv select input. Instantiate COLS_PER_CYCLE copies through a generate loop.
- The top level holds the FSM, col_q, state_q, the mode flags and the output InvShiftRows.

## Test plan
- Forward, COLS_PER_CYCLE=1:
  - Stimulus: in_state = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, inv=0, skip=0.
  - Required: out_state = 04 66 81 e5 e0 cb 19 9a 48 f8 d3 7a 28 06 26 4c, with out_valid rising exactly 5 cycles after acceptance.
- Inverse, COLS_PER_CYCLE=4:
  - Stimulus: in_state = 04 66 81 e5 …4c, inv=1.
  - Required: out_state = d4 27 11 ae …52 30, with out_valid 2 cycles after acceptance.
- Skip mix:
  - Stimulus: in_state = 00 01 02 … 0f, inv=0, skip=1.
  - Required: out_state = 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b, with 1-cycle latency.
  - Then repeat with inv=1 on that output; required: 00 01 … 0f.
- Column check:
  - Stimulus: single-column pattern db 13 53 45 in every column with rows pre-aligned (all four columns identical, so ShiftRows has no effect), COLS_PER_CYCLE=2.
  - Required: every column = 8e 4d a1 bc.
- Backpressure and back-to-back:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE.
  - Required: out_state stable and in_ready=0 during the stall.
  - Then raise out_ready with in_valid=1. Required: the new block is accepted in the same cycle, with no idle cycle between.
- Reset mid-MIX:
  - Stimulus: assert rst in the 2nd MIX cycle.
  - Required: next cycle out_valid=0, out_state=0, in_ready=1, and no stale result appears afterwards.
